// File: rtl/manchester_pkg.sv
// Shared constants and state encoding for the Manchester frame arbiter.
package manchester_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SOF_BYTE      = 8'hD5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SOF  = 3'd2,
        HDR  = 3'd3,
        PAY  = 3'd4,
        CHK  = 3'd5,
        GAP  = 3'd6
    } state_t;

    // Header byte carries the index of the requester that owns the frame.
    function automatic logic [7:0] src_id(input logic [1:0] gnt);
        return gnt[1] ? 8'h01 : 8'h00;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves away from the
// winner whenever the grant is accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // prio_q = 0 favours req0, 1 favours req1.
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !prio_q)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (accept && (gnt != 2'b00)) begin
            prio_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/manchester_frame_arbiter.sv
// Arbitrates two byte-stream requesters into framed output:
// preamble, SOF, source ID, payload, XOR checksum, then an idle gap.
module manchester_frame_arbiter
    import manchester_pkg::*;
#(
    parameter int PREAMBLE_LEN = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int MAX_LEN      = 64
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [7:0] req0_tdata,
    input  logic       req0_tvalid,
    input  logic       req0_tlast,
    output logic       req0_tready,
    input  logic [7:0] req1_tdata,
    input  logic       req1_tvalid,
    input  logic       req1_tlast,
    output logic       req1_tready,
    output logic [7:0] tx_tdata,
    output logic       tx_tvalid,
    input  logic       tx_tready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       frame_done,
    output logic       trunc,
    output logic [2:0] dbg_state
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] PAY_LAST = 8'(MAX_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       vld_q, vld_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] pay_cnt_q, pay_cnt_d;
    logic [7:0] csum_q, csum_d;
    logic       done_q, done_d;
    logic       trunc_q, trunc_d;

    logic [1:0] arb_gnt;
    logic [7:0] sel_tdata;
    logic       sel_tvalid;
    logic       sel_tlast;
    logic       in_pay;
    logic       xfer;

    rr_arbiter2 u_arb (
        .clk    (aclk),
        .rst    (areset),
        .req    ({req1_tvalid, req0_tvalid}),
        .accept (state_q == IDLE),
        .gnt    (arb_gnt)
    );

    // Valid/ready: a byte moves on any rising edge where valid and ready are
    // both high; a source holding valid keeps its data stable until then.
    // In PAY the granted requester is wired straight through to tx.
    always_comb begin
        in_pay      = (state_q == PAY) && !areset;
        sel_tdata   = grant_q[1] ? req1_tdata  : req0_tdata;
        sel_tvalid  = grant_q[1] ? req1_tvalid : req0_tvalid;
        sel_tlast   = grant_q[1] ? req1_tlast  : req0_tlast;
        tx_tvalid   = (state_q == PAY) ? (sel_tvalid && !areset) : vld_q;
        tx_tdata    = (state_q == PAY) ? sel_tdata : byte_q;
        req0_tready = in_pay && grant_q[0] && tx_tready;
        req1_tready = in_pay && grant_q[1] && tx_tready;
        xfer        = tx_tvalid && tx_tready;
        grant       = grant_q;
        busy        = (state_q != IDLE);
        frame_done  = done_q;
        trunc       = trunc_q;
        dbg_state   = state_q;
    end

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        vld_d     = vld_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        pay_cnt_d = pay_cnt_q;
        csum_d    = csum_q;
        done_d    = 1'b0;
        trunc_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    state_d   = PRE;
                    grant_d   = arb_gnt;
                    byte_d    = PREAMBLE_BYTE;
                    vld_d     = 1'b1;
                    cnt_d     = 8'd0;
                    pay_cnt_d = 8'd0;
                    csum_d    = 8'd0;
                end
            end
            PRE: begin
                if (xfer) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = SOF;
                        byte_d  = SOF_BYTE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            SOF: begin
                if (xfer) begin
                    state_d = HDR;
                    byte_d  = src_id(grant_q);
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d = PAY;
                    byte_d  = 8'd0;
                    vld_d   = 1'b0;
                end
            end
            PAY: begin
                if (xfer) begin
                    csum_d    = csum_q ^ sel_tdata;
                    pay_cnt_d = pay_cnt_q + 8'd1;
                    // A frame that hits MAX_LEN without tlast is cut here;
                    // the rest of the packet competes again from IDLE.
                    if (sel_tlast || (pay_cnt_q == PAY_LAST)) begin
                        state_d = CHK;
                        byte_d  = csum_q ^ sel_tdata;
                        vld_d   = 1'b1;
                        trunc_d = !sel_tlast;
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    state_d = GAP;
                    byte_d  = 8'd0;
                    vld_d   = 1'b0;
                    grant_d = 2'b00;
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            byte_q    <= 8'd0;
            vld_q     <= 1'b0;
            grant_q   <= 2'b00;
            cnt_q     <= 8'd0;
            pay_cnt_q <= 8'd0;
            csum_q    <= 8'd0;
            done_q    <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            vld_q     <= vld_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            pay_cnt_q <= pay_cnt_d;
            csum_q    <= csum_d;
            done_q    <= done_d;
            trunc_q   <= trunc_d;
        end
    end

endmodule

// File: tb/tb_manchester_frame_arbiter.sv
// Randomized bench for manchester_frame_arbiter: a packet-level model predicts
// every framed byte, and a monitor pops and compares each transferred byte.
module tb_manchester_frame_arbiter;

    localparam int PREAMBLE_LEN = 4;
    localparam int GAP_CYCLES   = 16;
    localparam int MAX_LEN      = 64;

    logic       aclk = 1'b0;
    logic       areset;
    logic [7:0] req0_tdata, req1_tdata;
    logic       req0_tvalid, req1_tvalid;
    logic       req0_tlast, req1_tlast;
    logic       req0_tready, req1_tready;
    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tready;
    logic [1:0] grant;
    logic       busy, frame_done, trunc;
    logic [2:0] dbg_state;

    manchester_frame_arbiter #(
        .PREAMBLE_LEN (PREAMBLE_LEN),
        .GAP_CYCLES   (GAP_CYCLES),
        .MAX_LEN      (MAX_LEN)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .req0_tdata  (req0_tdata),
        .req0_tvalid (req0_tvalid),
        .req0_tlast  (req0_tlast),
        .req0_tready (req0_tready),
        .req1_tdata  (req1_tdata),
        .req1_tvalid (req1_tvalid),
        .req1_tlast  (req1_tlast),
        .req1_tready (req1_tready),
        .tx_tdata    (tx_tdata),
        .tx_tvalid   (tx_tvalid),
        .tx_tready   (tx_tready),
        .grant       (grant),
        .busy        (busy),
        .frame_done  (frame_done),
        .trunc       (trunc),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [7:0] data;
        logic [1:0] gnt;
        logic       pay0;
        logic       pay1;
        logic       first;
        logic       chk;
        logic       trk;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] msg0_q[$];
    logic [7:0] msg1_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_frames_exp = 0;
    int         n_done = 0;
    int         favour = 0;
    int         ready_mode = 0;
    logic       mon_en = 1'b0;
    int         idle_cnt = 1000;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       done_due = 1'b0;
    logic       trunc_due = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion at %0t", name, $time);
    endtask

    function automatic void push_exp(input logic [7:0] d, input int win, input logic pay,
                                     input logic first, input logic chk, input logic trk);
        exp_t e;
        e.data  = d;
        e.gnt   = (win == 0) ? 2'b01 : 2'b10;
        e.pay0  = pay && (win == 0);
        e.pay1  = pay && (win == 1);
        e.first = first;
        e.chk   = chk;
        e.trk   = trk;
        exp_q.push_back(e);
    endfunction

    // Packet-level model: split each pending packet into frames of at most
    // MAX_LEN bytes, alternate owners when both have bytes left.
    task automatic model_round();
        int p0, p1, win, rem, n;
        logic h0, h1;
        logic [7:0] cs, b;
        p0 = 0;
        p1 = 0;
        while ((p0 < msg0_q.size()) || (p1 < msg1_q.size())) begin
            h0 = p0 < msg0_q.size();
            h1 = p1 < msg1_q.size();
            if (h0 && h1) win = favour;
            else          win = h0 ? 0 : 1;
            favour = 1 - win;
            rem = (win == 0) ? (msg0_q.size() - p0) : (msg1_q.size() - p1);
            n = (rem > MAX_LEN) ? MAX_LEN : rem;
            for (int k = 0; k < PREAMBLE_LEN; k++) push_exp(8'h55, win, 1'b0, k == 0, 1'b0, 1'b0);
            push_exp(8'hD5, win, 1'b0, 1'b0, 1'b0, 1'b0);
            push_exp((win == 0) ? 8'h00 : 8'h01, win, 1'b0, 1'b0, 1'b0, 1'b0);
            cs = 8'h00;
            for (int k = 0; k < n; k++) begin
                b = (win == 0) ? msg0_q[p0 + k] : msg1_q[p1 + k];
                cs = cs ^ b;
                push_exp(b, win, 1'b1, 1'b0, 1'b0, (k == n - 1) && (rem > MAX_LEN));
            end
            push_exp(cs, win, 1'b0, 1'b0, 1'b1, 1'b0);
            if (win == 0) p0 += n;
            else          p1 += n;
            n_frames_exp++;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic l);
        if (id == 0) begin
            req0_tvalid = v; req0_tdata = d; req0_tlast = l;
        end else begin
            req1_tvalid = v; req1_tdata = d; req1_tlast = l;
        end
    endtask

    task automatic drive(input int id);
        int n, waited;
        logic hs;
        logic [7:0] b;
        n = (id == 0) ? msg0_q.size() : msg1_q.size();
        for (int i = 0; i < n; i++) begin
            b = (id == 0) ? msg0_q[i] : msg1_q[i];
            set_req(id, 1'b1, b, i == n - 1);
            waited = 0;
            hs = 1'b0;
            while (!hs) begin
                @(negedge aclk);
                hs = (id == 0) ? (req0_tvalid && req0_tready) : (req1_tvalid && req1_tready);
                @(posedge aclk); #1;
                waited++;
                if (!hs && waited > 3000) begin
                    fail_now(id == 0 ? "req0_handshake" : "req1_handshake");
                    set_req(id, 1'b0, 8'h00, 1'b0);
                    return;
                end
            end
            // Bubbles only inside a frame, never where a new frame would start.
            if ((i != n - 1) && (((i + 1) % MAX_LEN) != 0) && ($urandom_range(0, 3) == 0)) begin
                set_req(id, 1'b0, 8'h00, 1'b0);
                @(posedge aclk); #1;
            end
        end
        set_req(id, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin : sink
        tx_tready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            case (ready_mode)
                0:       tx_tready = 1'b1;
                1:       tx_tready = ~tx_tready;
                default: tx_tready = ($urandom_range(0, 99) < 60);
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t h;
        logic have;
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                have = exp_q.size() > 0;
                h = have ? exp_q[0] : '0;
                if (stall_prev) begin
                    check("stall_valid", tx_tvalid, 1);
                    check("stall_data", tx_tdata, stall_data);
                end
                check("req0_tready", req0_tready, have && h.pay0 && tx_tready);
                check("req1_tready", req1_tready, have && h.pay1 && tx_tready);
                check("frame_done", frame_done, done_due);
                check("trunc", trunc, trunc_due);
                if (frame_done) n_done++;
                done_due = 1'b0;
                trunc_due = 1'b0;
                if (tx_tvalid && tx_tready) begin
                    if (!have) begin
                        check("unexpected_byte", tx_tdata, 32'hFFFF_FFFF);
                    end else begin
                        void'(exp_q.pop_front());
                        check("tx_tdata", tx_tdata, h.data);
                        check("grant", grant, h.gnt);
                        if (h.first)
                            check("gap_len", (idle_cnt >= GAP_CYCLES) ? GAP_CYCLES : idle_cnt, GAP_CYCLES);
                        done_due = h.chk;
                        trunc_due = h.trk;
                    end
                    idle_cnt = 0;
                end else if (!tx_tvalid) begin
                    idle_cnt++;
                end
                stall_prev = tx_tvalid && !tx_tready;
                stall_data = tx_tdata;
            end
        end
    end

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0) && (t < 5000)) begin
            @(posedge aclk);
            t++;
        end
        if (exp_q.size() > 0) begin
            fail_now("drain");
            exp_q.delete();
        end
        repeat (GAP_CYCLES + 4) @(posedge aclk);
        #1;
    endtask

    task automatic run_round(input int mode);
        ready_mode = mode;
        model_round();
        @(posedge aclk); #1;
        fork
            drive(0);
            drive(1);
        join
        wait_drain();
    endtask

    task automatic fill(input int id, input int len);
        if (id == 0) msg0_q.delete();
        else         msg1_q.delete();
        for (int i = 0; i < len; i++) begin
            if (id == 0) msg0_q.push_back(8'($urandom_range(0, 255)));
            else         msg1_q.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int waited, l0, l1;
        areset = 1'b1;
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tx_tvalid", tx_tvalid, 0);
        check("rst_tx_tdata", tx_tdata, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_trunc", trunc, 0);
        check("rst_req0_tready", req0_tready, 0);
        check("rst_req1_tready", req1_tready, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        mon_en = 1'b1;

        // Both requesting from reset, then both again.
        msg0_q = {8'hA1, 8'hA2};
        msg1_q = {8'hB1};
        run_round(0);
        msg0_q = {8'hC1};
        msg1_q = {8'hD1, 8'hD2};
        run_round(0);

        // Single short frame, free-running and stalled sink.
        msg0_q = {8'h12, 8'h34};
        msg1_q.delete();
        run_round(0);
        run_round(1);

        // Truncation: 70 bytes, then 64 vs 128 boundaries against each other.
        msg0_q.delete();
        fill(1, 70);
        run_round(0);
        fill(0, 64);
        fill(1, 128);
        run_round(2);

        for (int r = 0; r < 14; r++) begin
            l0 = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 140) : $urandom_range(1, 20);
            l1 = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 140) : $urandom_range(1, 20);
            if ($urandom_range(0, 3) == 0) l0 = 0;
            if ((l0 != 0) && ($urandom_range(0, 3) == 0)) l1 = 0;
            fill(0, l0);
            fill(1, l1);
            run_round($urandom_range(0, 2));
        end

        // Reset in the middle of a payload.
        mon_en = 1'b0;
        ready_mode = 0;
        @(posedge aclk); #1;
        set_req(0, 1'b1, 8'h40, 1'b0);
        waited = 0;
        do begin
            @(negedge aclk);
            waited++;
        end while (!req0_tready && waited < 200);
        if (!req0_tready) fail_now("reset_setup");
        @(posedge aclk); #1;
        set_req(0, 1'b1, 8'h41, 1'b0);
        @(negedge aclk);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(negedge aclk);
        check("mid_busy_before", busy, 1);
        check("mid_req0_tready_in_reset", req0_tready, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        set_req(0, 1'b1, 8'h77, 1'b1);
        @(negedge aclk);
        check("mid_tx_tvalid", tx_tvalid, 0);
        check("mid_tx_tdata", tx_tdata, 0);
        check("mid_grant", grant, 0);
        check("mid_busy", busy, 0);
        check("mid_frame_done", frame_done, 0);
        check("mid_trunc", trunc, 0);
        favour = 0;
        idle_cnt = 1000;
        stall_prev = 1'b0;
        done_due = 1'b0;
        trunc_due = 1'b0;
        msg0_q = {8'h77};
        msg1_q.delete();
        model_round();
        mon_en = 1'b1;
        drive(0);
        wait_drain();

        check("frame_count", n_done, n_frames_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
